// File: rtl/strip_frame_sequencer.sv
// -----------------------------------------------------------------------------
// strip_frame_sequencer
//
// Frame-level controller for the 8-strip LED wall shift-register driver.
// For each LED and each of its 24 colour bits (G7..G0, R7..R0, B7..B0) it
// fetches an 8-bit slice (one bit per strip) from the frame store. It then
// plays the WS2812 bit as three phases of PHASE_CYC cycles each:
// all-high (0xFF), data (the slice) and all-low (0x00).
//
// Each phase byte is shifted MSB first into an external 8-bit shift
// register (ser_out / sr_clk) and latched with r_clk. A frame ends with a
// RESET_CYC-cycle gap that shifts and latches 0x00 and then holds all lines
// low.
//
// Optional build macro:
//   FRAME_REPEAT_EN - at the end of the gap, restart the frame from LED 0
//                     instead of returning to idle. The loop runs until
//                     Reset is asserted.
//
// Ports:
//   clk_100     in   100 MHz system clock
//   Reset       in   asynchronous active-low reset
//   start       in   single-cycle frame start request (ignored while busy)
//   num_leds    in   LEDs per strip; captured on an accepted start
//   pix_req     out  pixel slice request, held until pix_ack or deadline
//   pix_led     out  LED index of the request
//   pix_bit     out  bit sequence number 0..23 of the request
//   pix_ack     in   one-cycle acknowledge, pix_data valid alongside
//   pix_data    in   bit s = colour bit for strip s
//   ser_out     out  shift-register serial data
//   sr_clk      out  shift-register shift clock
//   r_clk       out  shift-register latch clock
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse at end of frame
//   underrun    out  sticky: a slice fetch missed its deadline
// -----------------------------------------------------------------------------
module strip_frame_sequencer #(
  parameter int LED_W     = 10,
  parameter int PHASE_CYC = 40,
  parameter int RESET_CYC = 6000
) (
  input  logic             clk_100,
  input  logic             Reset,
  input  logic             start,
  input  logic [LED_W-1:0] num_leds,
  output logic             pix_req,
  output logic [LED_W-1:0] pix_led,
  output logic [4:0]       pix_bit,
  input  logic             pix_ack,
  input  logic [7:0]       pix_data,
  output logic             ser_out,
  output logic             sr_clk,
  output logic             r_clk,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int PC_MAX = (RESET_CYC > PHASE_CYC) ? RESET_CYC : PHASE_CYC;
  localparam int PC_W   = $clog2(PC_MAX);

  localparam logic [PC_W-1:0] PH_LAST  = PC_W'(PHASE_CYC - 1);
  localparam logic [PC_W-1:0] GAP_LAST = PC_W'(RESET_CYC - 1);
  localparam logic [PC_W-1:0] SHIFT_END = PC_W'(32);
  localparam logic [PC_W-1:0] LATCH_A  = PC_W'(33);
  localparam logic [PC_W-1:0] LATCH_B  = PC_W'(34);
  localparam logic [4:0]      LAST_BIT = 5'd23;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PH_HI   = 3'd1,
    PH_DATA = 3'd2,
    PH_LO   = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [4:0]       bit_q, bit_d;
  logic [LED_W-1:0] num_q, num_d;
  logic [7:0]       data_q, data_d;
  logic             req_q, req_d;
  logic             und_q, und_d;
  logic             done_q, done_d;
  logic             ser_q, ser_d;
  logic             srclk_q, srclk_d;
  logic             rclk_q, rclk_d;
  logic             busy_q, busy_d;
  logic [7:0]       byte_d;

  // Sequencing, fetch handshake and frame control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    led_d   = led_q;
    bit_d   = bit_q;
    num_d   = num_q;
    data_d  = data_q;
    req_d   = req_q;
    und_d   = und_q;
    done_d  = 1'b0;

    // An outstanding request ends on ack, or at the last PH_HI cycle.
    // A missed deadline plays the slice as all-zero and flags the underrun.
    if (req_q) begin
      if (pix_ack) begin
        req_d  = 1'b0;
        data_d = pix_data;
      end else if (state_q == PH_HI && pc_q == PH_LAST) begin
        req_d  = 1'b0;
        data_d = 8'h00;
        und_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && num_leds != '0) begin
          num_d   = num_leds;
          und_d   = 1'b0;
          state_d = PH_HI;
          pc_d    = '0;
          led_d   = '0;
          bit_d   = '0;
          req_d   = 1'b1;
        end
      end

      PH_HI, PH_DATA, PH_LO: begin
        if (pc_q == PH_LAST) begin
          pc_d = '0;
          if (state_q == PH_HI) begin
            state_d = PH_DATA;
          end else if (state_q == PH_DATA) begin
            state_d = PH_LO;
          end else if (bit_q != LAST_BIT) begin
            bit_d   = bit_q + 5'd1;
            state_d = PH_HI;
            req_d   = 1'b1;
          end else if (led_q != num_q - LED_W'(1)) begin
            led_d   = led_q + LED_W'(1);
            bit_d   = '0;
            state_d = PH_HI;
            req_d   = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      GAP: begin
        if (pc_q == GAP_LAST) begin
          pc_d   = '0;
          done_d = 1'b1;
`ifdef FRAME_REPEAT_EN
          state_d = PH_HI;
          led_d   = '0;
          bit_d   = '0;
          req_d   = 1'b1;
`else
          state_d = IDLE;
`endif
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Line decode from the next state, so that the external clocks come
  // straight from flops (glitch-free) and stay aligned with state_q/pc_q.
  always_comb begin
    byte_d  = 8'h00;
    ser_d   = 1'b0;
    srclk_d = 1'b0;
    rclk_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      PH_HI:   byte_d = 8'hFF;
      PH_DATA: byte_d = data_d;
      default: byte_d = 8'h00;
    endcase
    if (state_d != IDLE) begin
      if (pc_d < SHIFT_END) begin
        // Four cycles per bit, MSB first: ~pc[4:2] == 7-k.
        // The shift clock is high in the last two cycles of each bit.
        ser_d   = byte_d[~pc_d[4:2]];
        srclk_d = pc_d[1];
      end
      rclk_d = (pc_d == LATCH_A) || (pc_d == LATCH_B);
    end
  end

  always_ff @(posedge clk_100 or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      led_q   <= '0;
      bit_q   <= '0;
      num_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      und_q   <= 1'b0;
      done_q  <= 1'b0;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      led_q   <= led_d;
      bit_q   <= bit_d;
      num_q   <= num_d;
      data_q  <= data_d;
      req_q   <= req_d;
      und_q   <= und_d;
      done_q  <= done_d;
      ser_q   <= ser_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      busy_q  <= busy_d;
    end
  end

  assign pix_req    = req_q;
  assign pix_led    = led_q;
  assign pix_bit    = bit_q;
  assign ser_out    = ser_q;
  assign sr_clk     = srclk_q;
  assign r_clk      = rclk_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_strip_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_strip_frame_sequencer
//
// Self-checking bench for strip_frame_sequencer. The reference is a timeline
// model: from the cycle a frame starts, plain arithmetic on the elapsed cycle
// count gives LED, bit, phase and phase position, and from those the expected
// line levels. The bench also acts as the frame store. It picks an ack delay
// per bit, random or forced, and remembers the slice it delivered.
// -----------------------------------------------------------------------------
module tb_strip_frame_sequencer;

  localparam int P  = 40;
  localparam int RC = 6000;

  logic       clk_100 = 1'b0;
  logic       Reset;
  logic       start;
  logic [9:0] num_leds;
  logic       pix_req;
  logic [9:0] pix_led;
  logic [4:0] pix_bit;
  logic       pix_ack;
  logic [7:0] pix_data;
  logic       ser_out, sr_clk, r_clk, busy, frame_done, underrun;

  strip_frame_sequencer #(.LED_W(10), .PHASE_CYC(P), .RESET_CYC(RC)) dut (
    .clk_100    (clk_100),
    .Reset      (Reset),
    .start      (start),
    .num_leds   (num_leds),
    .pix_req    (pix_req),
    .pix_led    (pix_led),
    .pix_bit    (pix_bit),
    .pix_ack    (pix_ack),
    .pix_data   (pix_data),
    .ser_out    (ser_out),
    .sr_clk     (sr_clk),
    .r_clk      (r_clk),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk_100 = ~clk_100;

  int total = 0;
  int bad   = 0;

  // model state
  int         cyc       = 0;
  bit         act       = 0;   // frame in progress
  int         s         = 0;   // cycle of the first PH_HI cycle of the frame
  int         n         = 0;   // captured LED count
  bit         eund      = 0;   // expected underrun flag
  int         cur_d     = 0;   // ack delay (cycles after req rise) of current bit
  logic [7:0] cur_data  = 0;
  int         ack_mode  = 0;   // 0 random delay, 1 delay 2 / 0xA5, 2 immediate
  int         force_bi  = -1;  // bit index (led*24+bit) whose ack is withheld
  int         start_cyc = 0;
  int         done_cyc  = 0;
  bit         done_seen = 0;
  int         rclk_cnt  = 0;
  bit         prev_rclk = 0;

  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // One clock cycle: compare DUT lines with the model, then drive inputs.
  task automatic tick(input bit do_start, input int nl);
    int r, L, p, bi, pib, ph;
    bit e_req, e_ser, e_sr, e_rc, e_busy, e_done;
    int led_e, bit_e;
    logic [7:0] byt;
    @(posedge clk_100);
    #1;
    cyc++;
    r = 0; L = 0; p = -1; bi = 0; pib = -1; ph = 0;
    e_req = 0; e_ser = 0; e_sr = 0; e_rc = 0; e_done = 0;
    led_e = 0; bit_e = 0; byt = 8'h00;
    if (act) begin
      L = n * 72 * P;
      r = cyc - s;
      if (r == L + RC) begin
        e_done = 1;
`ifdef FRAME_REPEAT_EN
        s = cyc;
        r = 0;
`else
        act = 0;
`endif
      end
    end
    e_busy = act;
    if (act) begin
      if (r < L) begin
        bi    = r / (3 * P);
        pib   = r % (3 * P);
        ph    = pib / P;
        p     = pib % P;
        led_e = bi / 24;
        bit_e = bi % 24;
        if (pib == 0) begin
          case (ack_mode)
            1:       begin cur_d = 2; cur_data = 8'hA5; end
            2:       begin cur_d = 0; cur_data = 8'($urandom); end
            default: begin cur_d = $urandom_range(0, P + 3); cur_data = 8'($urandom); end
          endcase
          if (bi == force_bi) cur_d = P + 2;
        end
        if (ph == 0)      byt = 8'hFF;
        else if (ph == 1) byt = (cur_d < P) ? cur_data : 8'h00;
        e_req = (ph == 0) && (p <= cur_d);
      end else begin
        p = r - L;
      end
      if (p >= 0 && p < 32) begin
        e_sr  = (p % 4) >= 2;
        e_ser = byt[7 - p / 4];
      end
      e_rc = (p == 33) || (p == 34);
    end

    chk("pix_req", int'(pix_req), int'(e_req));
    chk("ser_out", int'(ser_out), int'(e_ser));
    chk("sr_clk", int'(sr_clk), int'(e_sr));
    chk("r_clk", int'(r_clk), int'(e_rc));
    chk("busy", int'(busy), int'(e_busy));
    chk("frame_done", int'(frame_done), int'(e_done));
    chk("underrun", int'(underrun), int'(eund));
    if (e_req) begin
      chk("pix_led", int'(pix_led), led_e);
      chk("pix_bit", int'(pix_bit), bit_e);
    end

    if (r_clk && !prev_rclk) rclk_cnt++;
    prev_rclk = r_clk;
    if (frame_done) begin
      done_seen = 1;
      done_cyc  = cyc;
    end

    // drive this cycle's inputs
    start    = do_start;
    num_leds = 10'(nl);
    pix_ack  = act && (pib >= 0) && (pib == cur_d);
    pix_data = pix_ack ? cur_data : 8'($urandom);

    // model updates that take effect next cycle
    if (act && pib == P - 1 && cur_d >= P) eund = 1;
    if (do_start && !act && nl != 0) begin
      act       = 1;
      s         = cyc + 1;
      n         = nl;
      eund      = 0;
      start_cyc = cyc;
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    done_seen = 0;
    while (!done_seen && k < budget) begin
      tick(0, 0);
      k++;
    end
    chk("frame_done_seen", int'(done_seen), 1);
  endtask

  initial begin
    int prev_done;
    Reset    = 1'b0;
    start    = 1'b0;
    num_leds = '0;
    pix_ack  = 1'b0;
    pix_data = '0;
    repeat (3) tick(0, 0);
    Reset = 1'b1;
    repeat (2) tick(0, 0);

    // start with zero LEDs is ignored
    tick(1, 0);
    repeat (5) tick(0, 0);
    $display("txn: start num_leds=0 busy=%0d pix_req=%0d", busy, pix_req);

`ifdef FRAME_REPEAT_EN
    ack_mode = 2;
    tick(1, 1);
    wait_done(20000);
    chk("first_frame_len", done_cyc - start_cyc, 8881);
    $display("txn: repeat first frame_done at +%0d", done_cyc - start_cyc);
    prev_done = done_cyc;
    repeat (2) begin
      wait_done(20000);
      chk("repeat_period", done_cyc - prev_done, 8880);
      chk("busy_after_repeat", int'(busy), 1);
      $display("txn: repeat frame_done period=%0d", done_cyc - prev_done);
      prev_done = done_cyc;
    end
`else
    // one LED, ack two cycles after each request with 0xA5
    ack_mode = 1;
    rclk_cnt = 0;
    tick(1, 1);
    wait_done(20000);
    chk("frame_len_n1", done_cyc - start_cyc, 8881);
    chk("rclk_pulses_n1", rclk_cnt, 73);
    chk("underrun_clean", int'(underrun), 0);
    $display("txn: n=1 ack+2 len=%0d rclk=%0d", done_cyc - start_cyc, rclk_cnt);

    // three LEDs, immediate ack, second start mid-frame
    ack_mode = 2;
    rclk_cnt = 0;
    tick(1, 3);
    repeat (100) tick(0, 0);
    tick(1, 2);
    wait_done(30000);
    chk("frame_len_n3", done_cyc - start_cyc, 14641);
    chk("rclk_pulses_n3", rclk_cnt, 217);
    chk("busy_after_n3", int'(busy), 0);
    $display("txn: n=3 immediate len=%0d rclk=%0d", done_cyc - start_cyc, rclk_cnt);

    // random ack delays, ack for led 0 bit 5 withheld
    ack_mode = 0;
    force_bi = 5;
    tick(1, 2);
    wait_done(30000);
    chk("frame_len_n2_underrun", done_cyc - start_cyc, 11761);
    repeat (3) tick(0, 0);
    chk("underrun_sticky", int'(underrun), 1);
    $display("txn: n=2 withheld ack len=%0d underrun=%0d", done_cyc - start_cyc, underrun);

    // reset mid-frame at led 1 bit 10, then a fresh frame
    force_bi = -1;
    tick(1, 2);
    while (act && (cyc - s) < 72 * P + 10 * 3 * P) tick(0, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_pix_req", int'(pix_req), 0);
    chk("rst_sr_clk", int'(sr_clk), 0);
    chk("rst_r_clk", int'(r_clk), 0);
    chk("rst_ser_out", int'(ser_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_pix_led", int'(pix_led), 0);
    $display("txn: async reset mid-frame pix_req=%0d busy=%0d", pix_req, busy);
    act  = 0;
    eund = 0;
    repeat (3) tick(0, 0);
    Reset = 1'b1;
    tick(0, 0);
    ack_mode = 2;
    tick(1, 1);
    wait_done(20000);
    chk("frame_len_after_reset", done_cyc - start_cyc, 8881);
    $display("txn: frame after reset len=%0d", done_cyc - start_cyc);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
